error_recovery_controller: RTL
==============================

// Module: error_recovery_controller
// PURPOSE
//  Downstream consumer of the per-stage timing-error flags (data-error AND transition).
//  Turns raw error pulses into pipeline control: freezes and flushes the pipe,
//  requests a replay from the erroring stage, and re-checks the pipe after the replay.
//  Escalates to a sticky fatal fault after repeated failed replays.
//  Sits between the stage error detectors and the core stall/flush/replay logic.
// PARAMETERS
//  NUM_STAGES    4   number of monitored stages; width of error_in
//  STALL_CYCLES  2   cycles stall is held in STALL before replay is requested (>=1)
//  WINDOW        4   post-replay observation cycles in WAIT_CLEAN (>=1)
//  MAX_RETRY     3   failed replays in a row before FAULT (>=1)
//  CNT_WIDTH     16  width of error_count
//  STAGE_W (localparam) = max(1, clog2(NUM_STAGES))
// PORTS
//  clk           in   1           clock, rising edge
//  reset         in   1           asynchronous, active-low (0 = in reset)
//  error_in      in   NUM_STAGES  per-stage error flags, bit i = stage i
//  stall         out  1           freeze pipeline
//  flush         out  1           one-cycle flush pulse
//  replay_req    out  1           replay request; held until acknowledged
//  replay_ack    in   1           replay accepted by core
//  replay_stage  out  STAGE_W     index of the stage to replay from
//  fatal         out  1           sticky unrecoverable-fault flag
//  fatal_clr     in   1           clears FAULT
//  error_count   out  CNT_WIDTH   accepted error events (see CONFIGURATION)
// BEHAVIOUR
//  - All outputs are registered. Reset asserted: state=IDLE; all outputs 0; retry=0; timer=0.
//  - Error event: |error_in sampled high in IDLE or WAIT_CLEAN. Detected at edge N, so
//    stall/flush are visible from cycle N+1. Lowest set bit index -> replay_stage, which holds until the next event.
//  - IDLE: stall=0, replay_req=0. Error event -> STALL. flush=1 for the first STALL cycle only.
//  - STALL: stall=1 for exactly STALL_CYCLES cycles, then -> REPLAY. error_in ignored.
//  - REPLAY: stall=1, replay_req=1 until replay_ack is sampled 1. On that edge:
//    replay_req->0, -> WAIT_CLEAN, timer loads WINDOW. error_in ignored.
//    An ack in the same cycle req first rises is valid.
//  - WAIT_CLEAN: stall=0; timer counts down each cycle.
//    Error event: retry+1. If the new retry==MAX_RETRY -> FAULT; otherwise -> STALL with a new flush
//    and replay_stage re-captured.
//    Timer reaches 0 with no error -> IDLE, retry=0.
//    Error in the same cycle the timer expires counts as an error (error wins).
//  - FAULT: stall=1, fatal=1, replay_req=0. Leaves only when fatal_clr is sampled 1 -> IDLE,
//    fatal=0, retry=0. fatal_clr outside FAULT is ignored.
//  - replay_ack outside REPLAY is ignored. Multiple error bits set at once = one event.
//  - Reset asserted mid-operation (any state) aborts immediately to reset values;
//    the count is lost.
// CONFIGURATION
//  ERR_STATS_EN defined:
//    error_count +1 per accepted error event.
//    Saturates at 2^CNT_WIDTH-1 (no wrap).
//    Cleared only by reset.
//  ERR_STATS_EN undefined:
//    error_count tied to 0; no counter flops.
//    All other behaviour identical.
// TESTING
//  1 Reset: reset=0 with error_in=4'hF -> all outputs 0, state IDLE; release -> outputs stay 0.
//  2 Single recovery: error_in=4'b0100 one cycle ->
//      stall high 2 cycles (flush on first), then replay_req=1, replay_stage=2;
//      ack after 3 cycles -> req drops; 4 clean cycles -> IDLE; error_count=1.
//  3 Priority: error_in=4'b1010 -> replay_stage=1. Errors during STALL/REPLAY leave count and stage unchanged.
//  4 Escalation: error re-injected in WAIT_CLEAN after each replay
//      -> 3rd failure enters FAULT, fatal=1, stall=1;
//      fatal_clr=1 -> IDLE, fatal=0.
//  5 Boundaries:
//      error on the last WAIT_CLEAN cycle -> counted as a retry.
//      Reset asserted during REPLAY -> replay_req=0 immediately.
//  6 Saturation (ERR_STATS_EN, CNT_WIDTH=2): 5 recovered events -> error_count=3.
//      Without the macro -> error_count stays 0.

Source files
------------

// File: rtl/error_recovery_controller_if.sv
// Handshake bundle between the stage error detectors / core control logic and
// error_recovery_controller. The master side is the controller.
interface error_recovery_controller_if #(
  parameter int NUM_STAGES = 4,
  parameter int CNT_WIDTH  = 16
);
  localparam int STAGE_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  logic [NUM_STAGES-1:0] error_in;
  logic                  stall;
  logic                  flush;
  logic                  replay_req;
  logic                  replay_ack;
  logic [STAGE_W-1:0]    replay_stage;
  logic                  fatal;
  logic                  fatal_clr;
  logic [CNT_WIDTH-1:0]  error_count;

  modport master (
    input  error_in, replay_ack, fatal_clr,
    output stall, flush, replay_req, replay_stage, fatal, error_count
  );

  modport slave (
    output error_in, replay_ack, fatal_clr,
    input  stall, flush, replay_req, replay_stage, fatal, error_count
  );
endinterface

// File: rtl/error_recovery_controller.sv
// Timing-error recovery FSM: stall/flush, replay request, post-replay check, fatal escalation.
// Define ERR_STATS_EN to build the saturating error_count; otherwise error_count is tied to 0.
module error_recovery_controller #(
  parameter int NUM_STAGES   = 4,
  parameter int STALL_CYCLES = 2,
  parameter int WINDOW       = 4,
  parameter int MAX_RETRY    = 3,
  parameter int CNT_WIDTH    = 16
) (
  input logic                        clk,
  input logic                        reset,
  error_recovery_controller_if.master bus
);
  localparam int STAGE_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int TMR_MAX = (STALL_CYCLES > WINDOW) ? STALL_CYCLES : WINDOW;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int RTY_W   = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STALL,
    S_REPLAY,
    S_WAIT_CLEAN,
    S_FAULT
  } state_e;

  state_e             state_q, state_d;
  logic               stall_q, stall_d;
  logic               flush_q, flush_d;
  logic               req_q, req_d;
  logic               fatal_q, fatal_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic [STAGE_W-1:0] first_idx;
  logic               any_err;

  assign any_err = |bus.error_in;

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    first_idx = '0;
    for (int unsigned i = NUM_STAGES; i > 0; i--) begin
      if (bus.error_in[i-1]) first_idx = STAGE_W'(i - 1);
    end
  end

  always_comb begin
    state_d = state_q;
    stall_d = stall_q;
    flush_d = 1'b0;
    req_d   = req_q;
    fatal_d = fatal_q;
    stage_d = stage_q;
    timer_d = timer_q;
    retry_d = retry_q;
    case (state_q)
      S_IDLE: begin
        if (any_err) begin
          state_d = S_STALL;
          stall_d = 1'b1;
          flush_d = 1'b1;
          stage_d = first_idx;
          timer_d = TMR_W'(STALL_CYCLES - 1);
        end
      end
      S_STALL: begin
        if (timer_q == '0) begin
          state_d = S_REPLAY;
          req_d   = 1'b1;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_REPLAY: begin
        if (bus.replay_ack) begin
          state_d = S_WAIT_CLEAN;
          req_d   = 1'b0;
          stall_d = 1'b0;
          timer_d = TMR_W'(WINDOW);
        end
      end
      S_WAIT_CLEAN: begin
        // An error on the final window cycle still wins over expiry.
        if (any_err) begin
          stage_d = first_idx;
          retry_d = retry_q + 1'b1;
          stall_d = 1'b1;
          if (retry_q == RTY_W'(MAX_RETRY - 1)) begin
            state_d = S_FAULT;
            fatal_d = 1'b1;
            timer_d = '0;
          end else begin
            state_d = S_STALL;
            flush_d = 1'b1;
            timer_d = TMR_W'(STALL_CYCLES - 1);
          end
        end else if (timer_q <= TMR_W'(1)) begin
          state_d = S_IDLE;
          retry_d = '0;
          timer_d = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_FAULT: begin
        if (bus.fatal_clr) begin
          state_d = S_IDLE;
          stall_d = 1'b0;
          fatal_d = 1'b0;
          retry_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      stall_q <= 1'b0;
      flush_q <= 1'b0;
      req_q   <= 1'b0;
      fatal_q <= 1'b0;
      stage_q <= '0;
      timer_q <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
      req_q   <= req_d;
      fatal_q <= fatal_d;
      stage_q <= stage_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
    end
  end

  assign bus.stall        = stall_q;
  assign bus.flush        = flush_q;
  assign bus.replay_req   = req_q;
  assign bus.fatal        = fatal_q;
  assign bus.replay_stage = stage_q;

`ifdef ERR_STATS_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (any_err && (state_q == S_IDLE || state_q == S_WAIT_CLEAN) && cnt_q != '1)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign bus.error_count = cnt_q;
`else
  assign bus.error_count = '0;
`endif
endmodule
